// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch-stage constants (widths, clock period, PC step, reset PC) and a sizing helper.
package fetch_prefetch_unit_pkg;

  localparam int unsigned FP_WORD      = 64;
  localparam int unsigned FP_INSTR_LEN = 32;
  localparam int unsigned FP_CYCLE     = 10;
  localparam int unsigned FP_PC_STEP   = 4;
  localparam int unsigned FP_DEPTH     = 4;
  localparam logic [63:0] FP_RESET_PC  = 64'd0;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry circular prefetch buffer; flush empties it, head is the oldest entry.
module fetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FP_DEPTH,
  parameter int unsigned EW    = FP_INSTR_LEN + FP_WORD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic                          i_flush,
  input  logic [EW-1:0]                 i_data,
  output logic [cnt_width(DEPTH)-1:0]   o_count,
  output logic [EW-1:0]                 o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: PC, 1-cycle imem reads, credit-limited queue, redirect flush.
// Optional FETCH_STATS_EN adds saturating flush/stall counters.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned     WORD      = FP_WORD,
  parameter int unsigned     INSTR_LEN = FP_INSTR_LEN,
  parameter int unsigned     DEPTH     = FP_DEPTH,
  parameter logic [WORD-1:0] RESET_PC  = WORD'(FP_RESET_PC),
  parameter int unsigned     PC_STEP   = FP_PC_STEP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      cur_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]          stat_flushes,
  output logic [31:0]          stat_stalls
`endif
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = INSTR_LEN + WORD;

  logic [WORD-1:0] r_fetch_pc;
  logic [WORD-1:0] r_inflight_pc;
  logic            r_inflight;

  logic [CW-1:0]   w_count;
  logic [EW-1:0]   w_head;
  logic [OW-1:0]   w_occ;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;

  // Occupancy after this cycle's pop, counting the read still in flight.
  assign instr_valid = (w_count != '0) && !pc_src;
  assign w_pop       = instr_valid && instr_ready;
  assign w_occ       = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_issue     = !reset && !pc_src && (w_occ < OW'(DEPTH));
  assign w_push      = r_inflight && !pc_src;

  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign instruction = w_head[EW-1 -: INSTR_LEN];
  assign cur_pc      = w_head[WORD-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (pc_src) begin
      r_fetch_pc <= branch_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + WORD'(PC_STEP);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (pc_src),
    .i_data  ({imem_rdata, r_inflight_pc}),
    .o_count (w_count),
    .o_head  (w_head)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_flushes;
  logic [31:0] r_stat_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_flushes <= '0;
      r_stat_stalls  <= '0;
    end else begin
      if (pc_src && (r_stat_flushes != '1)) begin
        r_stat_flushes <= r_stat_flushes + 32'd1;
      end
      if (!instr_valid && (r_stat_stalls != '1)) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign stat_flushes = r_stat_flushes;
  assign stat_stalls  = r_stat_stalls;
`endif

endmodule
